// File: rtl/chi_nullfresh_pipe.sv
// chi_nullfresh_pipe: two-share masked Keccak chi unit without fresh randomness.
// Each row bit is split into four share-domain terms that are registered
// (stage T) before any XOR recombination, then compressed back to two shares.
// Optional macro CHI_OUTREG_EN adds a registered output stage O (latency 2).
module chi_nullfresh_pipe #(
    parameter int ROWS  = 5,
    parameter int BEATS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5*ROWS-1:0] in_s1,
    input  logic [5*ROWS-1:0] in_s2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5*ROWS-1:0] out_s1,
    output logic [5*ROWS-1:0] out_s2,
    output logic              out_last
);

    localparam int W  = 5 * ROWS;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_TAG = CW'(BEATS - 1);

    // Combinational term outputs, one bit per output bit per term
    logic [W-1:0] t0_next;
    logic [W-1:0] t1_next;
    logic [W-1:0] t2_next;
    logic [W-1:0] t3_next;

    // Stage T: glitch barrier holding the uncompressed terms
    logic          t_valid_reg;
    logic [CW-1:0] t_tag_reg;
    logic [W-1:0]  t0_reg;
    logic [W-1:0]  t1_reg;
    logic [W-1:0]  t2_reg;
    logic [W-1:0]  t3_reg;

    logic [CW-1:0] cnt_reg;
    logic          en_t;
    logic          load_t;

    logic [W-1:0]  comp_s1;
    logic [W-1:0]  comp_s2;

    // Term generation: each term touches at most one share of x,z and a
    // cross-share AND, so no term ever combines both shares of one variable.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_term
            localparam int ROW = gi / 5;
            localparam int K   = gi % 5;
            localparam int UI  = ROW * 5 + ((K + 1) % 5);
            localparam int ZI  = ROW * 5 + ((K + 2) % 5);
            assign t0_next[gi] = in_s1[gi] ^ in_s1[ZI] ^ (in_s1[UI] & in_s1[ZI]);
            assign t1_next[gi] = in_s1[UI] & in_s2[ZI];
            assign t2_next[gi] = in_s2[UI] & in_s1[ZI];
            assign t3_next[gi] = in_s2[gi] ^ in_s2[ZI] ^ (in_s2[UI] & in_s2[ZI]);
        end
    endgenerate

    // Compression reads terms only from T flops
    assign comp_s1 = t0_reg ^ t1_reg;
    assign comp_s2 = t2_reg ^ t3_reg;

    assign load_t   = en_t & in_valid;
    assign in_ready = en_t;

    // Beat counter: advances only on an accepted input beat, wraps at BEATS-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load_t) begin
            cnt_reg <= (cnt_reg == LAST_TAG) ? '0 : cnt_reg + 1'b1;
        end
    end

    // Stage T: valid follows the enable; data and tag change only on a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid_reg <= 1'b0;
            t_tag_reg   <= '0;
            t0_reg      <= '0;
            t1_reg      <= '0;
            t2_reg      <= '0;
            t3_reg      <= '0;
        end else begin
            if (en_t) begin
                t_valid_reg <= in_valid;
            end
            if (load_t) begin
                t_tag_reg <= cnt_reg;
                t0_reg    <= t0_next;
                t1_reg    <= t1_next;
                t2_reg    <= t2_next;
                t3_reg    <= t3_next;
            end
        end
    end

`ifdef CHI_OUTREG_EN
    logic          o_valid_reg;
    logic [CW-1:0] o_tag_reg;
    logic [W-1:0]  o_s1_reg;
    logic [W-1:0]  o_s2_reg;
    logic          en_o;
    logic          load_o;

    assign en_o   = ~o_valid_reg | out_ready;
    assign en_t   = ~t_valid_reg | en_o;
    assign load_o = en_o & t_valid_reg;

    // Stage O: registered compressed shares so outputs come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_reg <= 1'b0;
            o_tag_reg   <= '0;
            o_s1_reg    <= '0;
            o_s2_reg    <= '0;
        end else begin
            if (en_o) begin
                o_valid_reg <= t_valid_reg;
            end
            if (load_o) begin
                o_tag_reg <= t_tag_reg;
                o_s1_reg  <= comp_s1;
                o_s2_reg  <= comp_s2;
            end
        end
    end

    assign out_valid = o_valid_reg;
    assign out_s1    = o_s1_reg;
    assign out_s2    = o_s2_reg;
    assign out_last  = o_valid_reg & (o_tag_reg == LAST_TAG);
`else
    assign en_t      = ~t_valid_reg | out_ready;
    assign out_valid = t_valid_reg;
    assign out_s1    = comp_s1;
    assign out_s2    = comp_s2;
    assign out_last  = t_valid_reg & (t_tag_reg == LAST_TAG);
`endif

endmodule
